// File: rtl/airlock_pkg.sv
// Shared definitions for the airlock sequencer: the controller state set and
// the default length of one pump (equalize) phase.
package airlock_pkg;

  localparam int unsigned PressCyclesDefault = 7;

  typedef enum logic [2:0] {
    StIdle,
    StEqOut,
    StOpenOuter,
    StEqIn,
    StOpenInner
  } state_e;

  typedef enum logic {
    GrantArrive = 1'b0,
    GrantDepart = 1'b1
  } grant_e;

endpackage

// File: rtl/airlock_sequencer_if.sv
// Request/grant handshake plus door and pump commands of the airlock.
// The master side issues requests; the slave side is the sequencer.
interface airlock_sequencer_if;

  logic arrive_req;
  logic depart_req;
  logic passed;
  logic pump_up;
  logic pump_down;
  logic outer_open;
  logic inner_open;
  logic arrive_ack;
  logic depart_ack;
  logic busy;
  logic pressurized;

  modport master (
    output arrive_req, depart_req, passed,
    input  pump_up, pump_down, outer_open, inner_open,
    input  arrive_ack, depart_ack, busy, pressurized
  );

  modport slave (
    input  arrive_req, depart_req, passed,
    output pump_up, pump_down, outer_open, inner_open,
    output arrive_ack, depart_ack, busy, pressurized
  );

endinterface

// File: rtl/lock_timer.sv
// 16-bit phase down-counter: load has priority over decrement, and the
// counter saturates at zero so zero_o stays asserted until the next load.
module lock_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        dec_i,
  output logic        zero_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 16'd0);

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock controller: latches arrive/depart requests, grants them
// round-robin from idle, and steps doors and pumps through the transfer.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int unsigned PRESS_CYCLES = PressCyclesDefault
) (
  input  logic                clk,
  input  logic                rst,
  airlock_sequencer_if.slave  bus
);

  localparam logic [15:0] LoadVal = 16'(PRESS_CYCLES - 1);

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;
  logic   dir_depart_q, dir_depart_d;
  logic   pend_arr_q, pend_arr_d;
  logic   pend_dep_q, pend_dep_d;
  logic   press_q, press_d;
  logic   arr_ack_q, arr_ack_d;
  logic   dep_ack_q, dep_ack_d;
  logic   grant_arr, grant_dep;
  logic   tmr_load, tmr_dec, tmr_zero;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    dir_depart_d = dir_depart_q;
    press_d      = press_q;
    arr_ack_d    = 1'b0;
    dep_ack_d    = 1'b0;
    grant_arr    = 1'b0;
    grant_dep    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // With both pending, serve the direction not served last time.
        if (pend_arr_q && (!pend_dep_q || (last_grant_q == GrantDepart))) begin
          grant_arr = 1'b1;
        end else if (pend_dep_q) begin
          grant_dep = 1'b1;
        end
        if (grant_arr) begin
          state_d      = press_q ? StEqOut : StOpenOuter;
          dir_depart_d = 1'b0;
          last_grant_d = GrantArrive;
          arr_ack_d    = 1'b1;
        end else if (grant_dep) begin
          state_d      = press_q ? StOpenInner : StEqIn;
          dir_depart_d = 1'b1;
          last_grant_d = GrantDepart;
          dep_ack_d    = 1'b1;
        end
      end
      StEqOut: begin
        if (tmr_zero) begin
          state_d = StOpenOuter;
          press_d = 1'b0;
        end
      end
      StOpenOuter: begin
        if (bus.passed) state_d = dir_depart_q ? StIdle : StEqIn;
      end
      StEqIn: begin
        if (tmr_zero) begin
          state_d = StOpenInner;
          press_d = 1'b1;
        end
      end
      StOpenInner: begin
        if (bus.passed) state_d = dir_depart_q ? StEqOut : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A request arriving on the grant edge stays latched for later.
    pend_arr_d = (pend_arr_q & ~grant_arr) | bus.arrive_req;
    pend_dep_d = (pend_dep_q & ~grant_dep) | bus.depart_req;
  end

  assign tmr_load = ((state_d == StEqOut) || (state_d == StEqIn)) && (state_d != state_q);
  assign tmr_dec  = (state_q == StEqOut) || (state_q == StEqIn);

  lock_timer u_lock_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (LoadVal),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantDepart;
      dir_depart_q <= 1'b0;
      pend_arr_q   <= 1'b0;
      pend_dep_q   <= 1'b0;
      press_q      <= 1'b1;
      arr_ack_q    <= 1'b0;
      dep_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      dir_depart_q <= dir_depart_d;
      pend_arr_q   <= pend_arr_d;
      pend_dep_q   <= pend_dep_d;
      press_q      <= press_d;
      arr_ack_q    <= arr_ack_d;
      dep_ack_q    <= dep_ack_d;
    end
  end

  assign bus.pump_down   = (state_q == StEqOut);
  assign bus.pump_up     = (state_q == StEqIn);
  assign bus.outer_open  = (state_q == StOpenOuter);
  assign bus.inner_open  = (state_q == StOpenInner);
  assign bus.arrive_ack  = arr_ack_q;
  assign bus.depart_ack  = dep_ack_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.pressurized = press_q;

endmodule

// File: doc/airlock_sequencer.md
AIRLOCK_SEQUENCER -- requirements
Module: airlock_sequencer

Interface
REQ-001 SHALL have parameter PRESS_CYCLES, default 7, number of clock cycles one pump (equalize) phase lasts; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port arrive_req  input  1  one-cycle pulse: vessel outside requests entry; already synchronized upstream.
REQ-005 SHALL have port depart_req  input  1  one-cycle pulse: vessel inside requests exit; already synchronized upstream.
REQ-006 SHALL have port passed  input  1  one-cycle pulse: vessel has cleared the currently open door.
REQ-007 SHALL have port pump_up  output  1  chamber pressurizing toward inner-side level.
REQ-008 SHALL have port pump_down  output  1  chamber depressurizing toward outer-side level.
REQ-009 SHALL have port outer_open  output  1  outer door open command.
REQ-010 SHALL have port inner_open  output  1  inner door open command.
REQ-011 SHALL have port arrive_ack  output  1  one-cycle pulse: arrive request granted.
REQ-012 SHALL have port depart_ack  output  1  one-cycle pulse: depart request granted.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port pressurized  output  1  chamber currently at inner-side level.

Function
REQ-015 SHALL use states IDLE, EQ_OUT, OPEN_OUTER, EQ_IN, OPEN_INNER; all door/pump outputs Moore-decoded from registered state and registered ack flops.
REQ-016 SHALL latch arrive_req/depart_req into pending_arrive/pending_depart at the sampling edge; a repeat pulse while pending is absorbed (no counting).
REQ-017 SHALL, in IDLE with any pending bit, grant at the next edge: leave IDLE, clear that pending bit, assert matching ack for exactly the first cycle of the new state.
REQ-018 SHALL arbitrate simultaneous pending bits round-robin using last_grant; grant the direction opposite last_grant.
REQ-019 SHALL sequence arrive as: EQ_OUT (only if pressurized=1) -> OPEN_OUTER -> EQ_IN -> OPEN_INNER -> IDLE.
REQ-020 SHALL sequence depart as: EQ_IN (only if pressurized=0) -> OPEN_INNER -> EQ_OUT -> OPEN_OUTER -> IDLE.
REQ-021 SHALL hold pump_down for exactly PRESS_CYCLES cycles in EQ_OUT and pump_up for exactly PRESS_CYCLES cycles in EQ_IN, then advance; pressurized updates to 0/1 on EQ_OUT/EQ_IN exit.
REQ-022 SHALL hold the door output in OPEN_OUTER/OPEN_INNER until passed is sampled high (including first cycle of the state), then advance next edge.
REQ-023 SHALL ignore passed in any other state.
REQ-024 SHALL never assert outer_open and inner_open together, nor any door output together with either pump output, nor pump_up with pump_down.
REQ-025 SHALL accept new requests during busy (pending only); no grant occurs before return to IDLE.
REQ-026 SHALL use a 16-bit down-counter loaded with PRESS_CYCLES-1 on pump-state entry; advance when it reads 0.

Reset
REQ-027 SHALL, while rst=0 at a clk edge, force state=IDLE, pending bits=0, last_grant=depart, counter=0, pressurized=1, all other outputs 0.
REQ-028 SHALL abort any transaction in progress on reset with no further outputs; pending requests are discarded.

Structure
REQ-029 SHALL take the state enumeration and PRESS_CYCLES default from shared package airlock_pkg.
REQ-030 SHALL implement the phase timer as sub-module lock_timer (load, decrement, zero flag).

Verification
REQ-031 Reset: rst=0 for 2 edges -> all outputs 0 except pressurized=1; busy=0.
REQ-032 Arrive, PRESS_CYCLES=7: arrive_req at edge E0 -> arrive_ack 1 cycle after E1; pump_down cycles E1..E7; outer_open from E8; passed at E10 -> pump_up 7 cycles; inner_open; passed -> IDLE, pressurized=1.
REQ-033 Depart while pressurized=1: no pump phase; inner_open in cycle after grant edge; passed -> pump_down 7 cycles -> outer_open; passed -> IDLE, pressurized=0.
REQ-034 arrive_req and depart_req same edge from reset -> arrive granted first, depart_ack only after return to IDLE; then a further simultaneous pair grants arrive (last_grant=depart).
REQ-035 passed pulses during IDLE and EQ_OUT -> no state change, pump count still exactly 7.
REQ-036 rst=0 at cycle 3 of EQ_IN -> next cycle all outputs 0, pressurized=1, prior pending depart discarded.
